score_overlay_ctrl: RTL and testbench
=====================================

Name: score_overlay_ctrl

Overview:
- Owns the two players' scores as BCD counters.
- Sequences the shared 8x8 digit glyph ROM during horizontal blanking: fetches one glyph row per on-screen cell into a 5-cell line buffer.
- Produces a per-pixel overlay_on bit for the video mixer during active video.
- Sits between game logic (goal pulses) and the pixel pipeline; it is the only master of the digit ROM.

Parameters:
- X0, 256: left screen column of the scoreboard.
- Y0, 16: top screen line of the scoreboard.
- SCALE_SHIFT, 2: each font pixel is drawn as (1<<SCALE_SHIFT) x (1<<SCALE_SHIFT) screen pixels.
- WIN_SCORE, 7: binary score value at which the match ends.

Ports:
- clk  in  1  system/pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- goal_p1  in  1  one-cycle pulse: player 1 scored.
- goal_p2  in  1  one-cycle pulse: player 2 scored.
- score_clr  in  1  synchronous clear of scores and match_over.
- frame_start  in  1  one-cycle pulse at start of vblank.
- line_start  in  1  one-cycle pulse at start of hblank, preceding line next_y.
- next_y  in  10  line about to be drawn.
- draw_x  in  10  current active-video column.
- rom_char  out  4  glyph index to digit ROM.
- rom_row  out  3  glyph row to digit ROM.
- rom_pixels  in  8  ROM row data, combinational, MSB = leftmost pixel.
- p1_tens, p1_ones, p2_tens, p2_ones  out  4 each  live BCD scores.
- match_over  out  1  a player has reached WIN_SCORE.
- fetch_busy  out  1  fetch FSM not IDLE.
- overlay_on  out  1  scoreboard pixel lit at draw_x, registered.

Behaviour:
- Reset: all scores 0, match_over 0, FSM IDLE, line buffer 0, line_valid 0, display snapshot 0, rom_char 4'hF, rom_row 0, fetch_busy 0, overlay_on 0.

Scores:
- Each goal pulse increments that player's BCD pair: ones wraps 9->0 with carry into tens.
- Scores saturate at 99.
- goal_p1 and goal_p2 in the same cycle both increment.
- score_clr has priority over goals in the same cycle.
- Goals are ignored while match_over=1.
- match_over is set on the edge after either player's binary value equals WIN_SCORE.
- match_over is cleared only by score_clr or reset.

Snapshot:
- Displayed digits are copied from the live scores on frame_start, so a score change never tears mid-frame.
- A goal and frame_start in the same cycle: the snapshot takes the pre-increment value.

Cells (left to right):
- 0 = P1 tens, 1 = P1 ones, 2 = blank (char 4'hF), 3 = P2 tens, 4 = P2 ones.
- Window width is 40<<SCALE_SHIFT; height is 8<<SCALE_SHIFT.

Fetch FSM (IDLE, FETCH):
- IDLE, line_start with next_y inside [Y0, Y0+(8<<SCALE_SHIFT)):
  - latch row_q = (next_y-Y0)>>SCALE_SHIFT, cell=0, go FETCH.
- IDLE, line_start with next_y outside the window: line_valid<=0, stay IDLE.
- FETCH:
  - rom_char = snapshot digit of cell (4'hF for cell 2); rom_row = row_q.
  - Each edge: buf[cell]<=rom_pixels, cell++.
  - After cell 4: line_valid<=1, go IDLE.
- fetch_busy is high for exactly 5 cycles after the line_start edge.
- line_start during FETCH aborts and restarts the fetch from cell 0 with the new next_y; line_valid<=0.
- In IDLE, rom_char = 4'hF.

Pixel output:
- Registered, 1-cycle latency from draw_x.
- overlay_on = line_valid and draw_x inside [X0, X0+(40<<SCALE_SHIFT)) and buf[c][7-b].
- c = (draw_x-X0)>>(3+SCALE_SHIFT); b = ((draw_x-X0)>>SCALE_SHIFT)&7.
- Subtraction uses 10-bit unsigned arithmetic after the range check.

Reset mid-operation:
- Asynchronous: returns the FSM to IDLE, clears the buffer, forces overlay_on=0 immediately.

Optional Feature:
- Macro: SCORE_BLINK_EN.
- With SCORE_BLINK_EN:
  - An accepted goal loads a 6-bit frame countdown with 63 for the scoring player; simultaneous goals load both.
  - The countdown decrements on each frame_start.
  - While nonzero and countdown[3]=1, that player's two cells fetch char 4'hF (blank).
  - A new goal reloads 63.
  - score_clr zeroes both countdowns.
- Without SCORE_BLINK_EN: no counters; digits are always drawn.

Test Plan:
- Reset, then 12 goal_p1 pulses, WIN_SCORE=99 override -> p1_tens=1, p1_ones=2; at 99 a further pulse leaves 9/9.
- Default WIN_SCORE=7: 7 goal_p2 pulses -> match_over=1 next edge; an 8th pulse leaves p2_ones=7; score_clr -> all 0, match_over=0.
- Scores 3:5, frame_start, line_start with next_y=Y0+5 (row_q=1) -> rom_row=1 and rom_char sequence 0,3,F,0,5 on consecutive cycles; fetch_busy high 5 cycles.
- After that fetch, sweep draw_x from X0 with a glyph row of 8'b00111000 in cell 1 -> overlay_on high for draw_x X0+40..X0+51 (SCALE_SHIFT=2), one cycle later; low for draw_x<X0 and draw_x>=X0+160.
- line_start at next_y=Y0+2, second line_start 2 cycles later at next_y=Y0+40 -> fetch aborted, line_valid=0, overlay_on stays 0 on that line.
- SCORE_BLINK_EN: goal_p1, then frame_start pulses -> P1 cells blank on the frames where countdown[3]=1; after 63 frames steady.

Source files
------------

// File: rtl/score_overlay_ctrl.sv
// Two-player BCD scoreboard with hblank glyph-row fetch and per-pixel overlay output.
// Optional build macro SCORE_BLINK_EN blanks a player's digits for a while after each goal.
module score_overlay_ctrl #(
  parameter int X0          = 256,
  parameter int Y0          = 16,
  parameter int SCALE_SHIFT = 2,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       goal_p1,
  input  logic       goal_p2,
  input  logic       score_clr,
  input  logic       frame_start,
  input  logic       line_start,
  input  logic [9:0] next_y,
  input  logic [9:0] draw_x,
  output logic [3:0] rom_char,
  output logic [2:0] rom_row,
  input  logic [7:0] rom_pixels,
  output logic [3:0] p1_tens,
  output logic [3:0] p1_ones,
  output logic [3:0] p2_tens,
  output logic [3:0] p2_ones,
  output logic       match_over,
  output logic       fetch_busy,
  output logic       overlay_on
);

  localparam logic [9:0] X_LO  = 10'(X0);
  localparam logic [9:0] X_HI  = 10'(X0 + (40 << SCALE_SHIFT));
  localparam logic [9:0] Y_LO  = 10'(Y0);
  localparam logic [9:0] Y_HI  = 10'(Y0 + (8 << SCALE_SHIFT));
  localparam logic [6:0] WIN_B = 7'(WIN_SCORE);
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic {IDLE, FETCH} state_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)           return s;
    else if (s[3:0] == 4'd9)  return {s[7:4] + 4'd1, 4'd0};
    else                      return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_bin(input logic [7:0] s);
    return {3'b000, s[7:4]} * 7'd10 + {3'b000, s[3:0]};
  endfunction

  function automatic logic [3:0] cell_char(input logic [2:0] c, input logic [15:0] snap,
                                           input logic bl1, input logic bl2);
    case (c)
      3'd0:    return bl1 ? BLANK : snap[15:12];
      3'd1:    return bl1 ? BLANK : snap[11:8];
      3'd3:    return bl2 ? BLANK : snap[7:4];
      3'd4:    return bl2 ? BLANK : snap[3:0];
      default: return BLANK;
    endcase
  endfunction

  logic [7:0]  p1_q, p1_d, p2_q, p2_d;
  logic        match_q, match_d;
  logic [15:0] snap_q, snap_d;
  logic        acc1, acc2, blank1, blank2;

  assign acc1 = goal_p1 & ~match_q & ~score_clr;
  assign acc2 = goal_p2 & ~match_q & ~score_clr;

`ifdef SCORE_BLINK_EN
  logic [5:0] blk1_q, blk1_d, blk2_q, blk2_d;

  always_comb begin
    blk1_d = blk1_q;
    blk2_d = blk2_q;
    if (score_clr) begin
      blk1_d = '0;
      blk2_d = '0;
    end else begin
      if (acc1)                             blk1_d = 6'd63;
      else if (frame_start && blk1_q != 0)  blk1_d = blk1_q - 6'd1;
      if (acc2)                             blk2_d = 6'd63;
      else if (frame_start && blk2_q != 0)  blk2_d = blk2_q - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk1_q <= '0;
      blk2_q <= '0;
    end else begin
      blk1_q <= blk1_d;
      blk2_q <= blk2_d;
    end
  end

  assign blank1 = (blk1_q != 6'd0) & blk1_q[3];
  assign blank2 = (blk2_q != 6'd0) & blk2_q[3];
`else
  assign blank1 = 1'b0;
  assign blank2 = 1'b0;
`endif

  // Match state is judged on the registered scores, so it lands one edge after the winning goal.
  always_comb begin
    p1_d    = p1_q;
    p2_d    = p2_q;
    match_d = match_q;
    snap_d  = frame_start ? {p1_q, p2_q} : snap_q;
    if (score_clr) begin
      p1_d    = '0;
      p2_d    = '0;
      match_d = 1'b0;
    end else begin
      if (acc1) p1_d = bcd_inc(p1_q);
      if (acc2) p2_d = bcd_inc(p2_q);
      if (bcd_bin(p1_q) == WIN_B || bcd_bin(p2_q) == WIN_B) match_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q    <= '0;
      p2_q    <= '0;
      match_q <= 1'b0;
      snap_q  <= '0;
    end else begin
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      match_q <= match_d;
      snap_q  <= snap_d;
    end
  end

  state_t          state_q;
  logic [2:0]      cell_q;
  logic [4:0][7:0] lbuf_q;
  logic            line_valid_q;
  logic [3:0]      rom_char_q;
  logic [2:0]      rom_row_q;
  logic            fetch_busy_q;
  logic            y_in;
  logic [9:0]      y_off;

  assign y_in  = (next_y >= Y_LO) && (next_y < Y_HI);
  assign y_off = next_y - Y_LO;

  // rom_char is registered one cell ahead so the ROM answer is ready at the capturing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cell_q       <= '0;
      lbuf_q       <= '0;
      line_valid_q <= 1'b0;
      rom_char_q   <= BLANK;
      rom_row_q    <= '0;
      fetch_busy_q <= 1'b0;
    end else if (line_start) begin
      line_valid_q <= 1'b0;
      cell_q       <= '0;
      if (y_in) begin
        state_q      <= FETCH;
        rom_row_q    <= 3'(y_off >> SCALE_SHIFT);
        rom_char_q   <= cell_char(3'd0, snap_q, blank1, blank2);
        fetch_busy_q <= 1'b1;
      end else begin
        state_q      <= IDLE;
        rom_char_q   <= BLANK;
        fetch_busy_q <= 1'b0;
      end
    end else if (state_q == FETCH) begin
      lbuf_q[cell_q] <= rom_pixels;
      if (cell_q == 3'd4) begin
        state_q      <= IDLE;
        line_valid_q <= 1'b1;
        rom_char_q   <= BLANK;
        fetch_busy_q <= 1'b0;
      end else begin
        cell_q     <= cell_q + 3'd1;
        rom_char_q <= cell_char(cell_q + 3'd1, snap_q, blank1, blank2);
      end
    end
  end

  logic       x_in, overlay_d, overlay_q;
  logic [9:0] x_off;
  logic [2:0] pix_c, pix_b;

  assign x_in  = (draw_x >= X_LO) && (draw_x < X_HI);
  assign x_off = draw_x - X_LO;
  assign pix_c = 3'(x_off >> (3 + SCALE_SHIFT));
  assign pix_b = 3'(x_off >> SCALE_SHIFT);

  always_comb begin
    overlay_d = 1'b0;
    if (line_valid_q && x_in) overlay_d = lbuf_q[pix_c][3'd7 - pix_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overlay_q <= 1'b0;
    else        overlay_q <= overlay_d;
  end

  assign rom_char   = rom_char_q;
  assign rom_row    = rom_row_q;
  assign p1_tens    = p1_q[7:4];
  assign p1_ones    = p1_q[3:0];
  assign p2_tens    = p2_q[7:4];
  assign p2_ones    = p2_q[3:0];
  assign match_over = match_q;
  assign fetch_busy = fetch_busy_q;
  assign overlay_on = overlay_q;

endmodule

// File: tb/tb_score_overlay_ctrl.sv
// Directed bench for score_overlay_ctrl: scores, match end, fetch sequencing, pixel overlay, abort, reset.
module tb_score_overlay_ctrl;

  localparam int X0 = 256;
  localparam int Y0 = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       goal_p1, goal_p2, score_clr, frame_start, line_start;
  logic [9:0] next_y, draw_x;
  logic [3:0] rom_char;
  logic [2:0] rom_row;
  logic [7:0] rom_pixels;
  logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;
  logic       match_over, fetch_busy, overlay_on;

  logic       g99;
  logic [3:0] b_char, b_p1t, b_p1o, b_p2t, b_p2o;
  logic [2:0] b_row;
  logic       b_match, b_busy, b_ovl;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in digit ROM: only glyph 3 has lit pixels on any row.
  always_comb rom_pixels = (rom_char == 4'h3) ? 8'b0011_1000 : 8'h00;

  score_overlay_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .goal_p1(goal_p1), .goal_p2(goal_p2), .score_clr(score_clr),
    .frame_start(frame_start), .line_start(line_start), .next_y(next_y), .draw_x(draw_x),
    .rom_char(rom_char), .rom_row(rom_row), .rom_pixels(rom_pixels),
    .p1_tens(p1_tens), .p1_ones(p1_ones), .p2_tens(p2_tens), .p2_ones(p2_ones),
    .match_over(match_over), .fetch_busy(fetch_busy), .overlay_on(overlay_on)
  );

  score_overlay_ctrl #(.WIN_SCORE(99)) u_dut99 (
    .clk(clk), .rst_n(rst_n), .goal_p1(g99), .goal_p2(1'b0), .score_clr(1'b0),
    .frame_start(1'b0), .line_start(1'b0), .next_y(10'd0), .draw_x(10'd0),
    .rom_char(b_char), .rom_row(b_row), .rom_pixels(8'h00),
    .p1_tens(b_p1t), .p1_ones(b_p1o), .p2_tens(b_p2t), .p2_ones(b_p2o),
    .match_over(b_match), .fetch_busy(b_busy), .overlay_on(b_ovl)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int who);
    if (who == 1) goal_p1 = 1'b1;
    else if (who == 2) goal_p2 = 1'b1;
    else g99 = 1'b1;
    step();
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
    g99     = 1'b0;
    step();
  endtask

  task automatic start_line(input int y);
    next_y     = 10'(y);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [3:0] exp_c;
    rst_n = 1'b0; goal_p1 = 0; goal_p2 = 0; score_clr = 0; frame_start = 0;
    line_start = 0; next_y = '0; draw_x = '0; g99 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_score", {p1_tens, p1_ones, p2_tens, p2_ones}, 16'h0000);
    chk("rst_match", match_over, 1'b0);
    chk("rst_char",  rom_char, 4'hF);
    chk("rst_row",   rom_row, 3'd0);
    chk("rst_busy",  fetch_busy, 1'b0);
    chk("rst_ovl",   overlay_on, 1'b0);
    rst_n = 1'b1;
    step();

    // Counting past a tens boundary, then saturation at 99.
    repeat (12) pulse(3);
    chk("p1_12", {b_p1t, b_p1o}, 8'h12);
    repeat (87) pulse(3);
    chk("p1_99", {b_p1t, b_p1o}, 8'h99);
    pulse(3);
    chk("p1_sat", {b_p1t, b_p1o}, 8'h99);

    // Win detection at 7 on the default instance.
    repeat (6) pulse(2);
    goal_p2 = 1'b1;
    step();
    goal_p2 = 1'b0;
    chk("p2_7", {p2_tens, p2_ones}, 8'h07);
    chk("match_pre", match_over, 1'b0);
    step();
    chk("match_set", match_over, 1'b1);
    pulse(2);
    chk("p2_frozen", {p2_tens, p2_ones}, 8'h07);
    chk("match_hold", match_over, 1'b1);
    score_clr = 1'b1; goal_p1 = 1'b1;
    step();
    score_clr = 1'b0; goal_p1 = 1'b0;
    chk("clr_score", {p1_tens, p1_ones, p2_tens, p2_ones}, 16'h0000);
    chk("clr_match", match_over, 1'b0);
    goal_p1 = 1'b1; goal_p2 = 1'b1;
    step();
    goal_p1 = 1'b0; goal_p2 = 1'b0;
    chk("both_goal", {p1_tens, p1_ones, p2_tens, p2_ones}, 16'h0101);

    // Build 3:5, snapshot it, fetch row 1.
    repeat (2) pulse(1);
    repeat (4) pulse(2);
    chk("score_35", {p1_tens, p1_ones, p2_tens, p2_ones}, 16'h0305);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    start_line(Y0 + 5);
    chk("row", rom_row, 3'd1);
    chk("busy0", fetch_busy, 1'b1);
    chk("char0", rom_char, 4'h0);
    step(); chk("char1", rom_char, 4'h3); chk("busy1", fetch_busy, 1'b1);
    step(); chk("char2", rom_char, 4'hF); chk("busy2", fetch_busy, 1'b1);
    step(); chk("char3", rom_char, 4'h0); chk("busy3", fetch_busy, 1'b1);
    step(); chk("char4", rom_char, 4'h5); chk("busy4", fetch_busy, 1'b1);
    step(); chk("busy_end", fetch_busy, 1'b0); chk("char_idle", rom_char, 4'hF);

    // Pixel sweep across the whole scoreboard plus margins.
    for (int x = X0 - 4; x < X0 + 164; x++) begin
      draw_x = 10'(x);
      step();
      chk("ovl_sweep", overlay_on, (x >= X0 + 40 && x < X0 + 52));
    end

    // Abort a fetch with a line_start outside the window.
    start_line(Y0 + 2);
    step();
    start_line(Y0 + 40);
    chk("abort_busy", fetch_busy, 1'b0);
    repeat (5) step();
    draw_x = 10'(X0 + 45);
    step();
    chk("abort_ovl", overlay_on, 1'b0);

    // Refetch, confirm lit pixel, then assert reset mid-fetch.
    start_line(Y0 + 5);
    repeat (5) step();
    step();
    chk("refetch_ovl", overlay_on, 1'b1);
    start_line(Y0 + 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ovl",  overlay_on, 1'b0);
    chk("arst_busy", fetch_busy, 1'b0);
    chk("arst_char", rom_char, 4'hF);
    step();
    rst_n = 1'b1;
    step();

    // Goal coinciding with frame_start: snapshot keeps the old digit.
    goal_p1 = 1'b1; frame_start = 1'b1;
    step();
    goal_p1 = 1'b0; frame_start = 1'b0;
    chk("live_inc", {p1_tens, p1_ones}, 8'h01);
    start_line(Y0);
    step();
`ifdef SCORE_BLINK_EN
    exp_c = 4'hF;
`else
    exp_c = 4'h0;
`endif
    chk("snap_pre", rom_char, exp_c);
    repeat (5) step();

`ifdef SCORE_BLINK_EN
    score_clr = 1'b1;
    step();
    score_clr = 1'b0;
    pulse(1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    cnt = 62;
    for (int k = 0; k < 66; k++) begin
      start_line(Y0);
      exp_c = (cnt != 0 && cnt[3]) ? 4'hF : 4'h0;
      chk("blink_c0", rom_char, exp_c);
      step();
      exp_c = (cnt != 0 && cnt[3]) ? 4'hF : 4'h1;
      chk("blink_c1", rom_char, exp_c);
      repeat (4) step();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      if (cnt > 0) cnt--;
    end
`else
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    start_line(Y0);
    step();
    chk("digit_c1", rom_char, 4'h1);
    repeat (4) step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
